// File: rtl/output_argmax_if.sv
// output_argmax_if: score stream in, held argmax result out with ack handshake.
interface output_argmax_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
);
  logic              clear;
  logic              score_valid;
  logic [DATA_W-1:0] score_data;
  logic              score_ready;
  logic              result_valid;
  logic              result_ack;
  logic [IDX_W-1:0]  result_class;
  logic [DATA_W-1:0] result_score;
  logic [DATA_W-1:0] result_margin;
  logic              busy;
  modport master (
    output clear, score_valid, score_data, result_ack,
    input  score_ready, result_valid, result_class, result_score, result_margin, busy
  );
  modport slave (
    input  clear, score_valid, score_data, result_ack,
    output score_ready, result_valid, result_class, result_score, result_margin, busy
  );
endinterface

// File: rtl/output_argmax.sv
// output_argmax: tracks max/runner-up over NUM_CLASSES sequential scores and holds the winner until acked.
module output_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 8,
  parameter int IDX_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  output_argmax_if.slave    bus
);
  typedef enum logic {COLLECT, DONE} state_t;
  state_t r_state, w_state;
  logic [IDX_W-1:0]  r_count, w_count, r_idx, w_idx, r_class, w_class, w_idx_u;
  logic [DATA_W-1:0] r_max, w_max, r_second, w_second, r_score, w_score, r_margin, w_margin;
  logic [DATA_W-1:0] w_max_u, w_sec_u;
  logic r_ready, w_ready, r_valid, w_valid, r_busy, w_busy;
  logic w_accept, w_first, w_gt_max, w_gt_sec, w_last;
  assign w_accept = bus.score_valid && r_ready;
  assign w_first  = r_count == '0;
  assign w_gt_max = bus.score_data > r_max;
  assign w_gt_sec = bus.score_data > r_second;
  assign w_last   = w_accept && r_count == IDX_W'(NUM_CLASSES - 1);
  // strict compare keeps the lowest index on ties; an equal score still lifts the runner-up
  assign w_max_u = w_first ? bus.score_data : w_gt_max ? bus.score_data : r_max;
  assign w_sec_u = w_first ? '0 : w_gt_max ? r_max : w_gt_sec ? bus.score_data : r_second;
  assign w_idx_u = w_first ? '0 : w_gt_max ? r_count : r_idx;
  always_comb begin
    w_state  = r_state;
    w_count  = r_count;
    w_max    = r_max;
    w_second = r_second;
    w_idx    = r_idx;
    w_class  = r_class;
    w_score  = r_score;
    w_margin = r_margin;
    w_ready  = r_ready;
    w_valid  = r_valid;
    w_busy   = r_busy;
    if (bus.clear) begin
      w_state  = COLLECT;
      w_count  = '0;
      w_max    = '0;
      w_second = '0;
      w_idx    = '0;
      w_busy   = 1'b0;
      w_valid  = 1'b0;
      w_ready  = 1'b1;
    end else if (r_state == COLLECT) begin
      if (w_accept) begin
        w_count  = r_count + 1'b1;
        w_max    = w_max_u;
        w_second = w_sec_u;
        w_idx    = w_idx_u;
        w_busy   = 1'b1;
      end
      if (w_last) begin
        w_state  = DONE;
        w_count  = '0;
        w_busy   = 1'b0;
        w_valid  = 1'b1;
        w_ready  = 1'b0;
        w_class  = w_idx_u;
        w_score  = w_max_u;
        w_margin = w_max_u - w_sec_u;
      end
    end else if (bus.result_ack) begin
      w_state = COLLECT;
      w_valid = 1'b0;
      w_ready = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= COLLECT;
      r_count  <= '0;
      r_max    <= '0;
      r_second <= '0;
      r_idx    <= '0;
      r_class  <= '0;
      r_score  <= '0;
      r_margin <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_count  <= w_count;
      r_max    <= w_max;
      r_second <= w_second;
      r_idx    <= w_idx;
      r_class  <= w_class;
      r_score  <= w_score;
      r_margin <= w_margin;
      r_ready  <= w_ready;
      r_valid  <= w_valid;
      r_busy   <= w_busy;
    end
  end
  assign bus.score_ready   = r_ready;
  assign bus.result_valid  = r_valid;
  assign bus.result_class  = r_class;
  assign bus.result_score  = r_score;
  assign bus.result_margin = r_margin;
  assign bus.busy          = r_busy;
endmodule

// File: tb/tb_output_argmax.sv
// tb_output_argmax: directed and randomized scenarios checked against a top-2 reference model.
module tb_output_argmax;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  output_argmax_if #(.DATA_W(8), .IDX_W(4)) bus ();
  output_argmax #(.NUM_CLASSES(10), .DATA_W(8), .IDX_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic void model(input logic [7:0] s[$], output logic [3:0] c, output logic [7:0] m, output logic [7:0] g);
    logic [7:0] sec;
    c = '0;
    m = s[0];
    for (int i = 1; i < s.size(); i++) if (s[i] > m) begin m = s[i]; c = 4'(i); end
    sec = '0;
    for (int i = 0; i < s.size(); i++) if (i != int'(c) && s[i] > sec) sec = s[i];
    g = m - sec;
  endfunction
  task automatic send(input logic [7:0] d, input int gap);
    int n = 0;
    bus.score_valid = 1'b1;
    bus.score_data = d;
    while (!bus.score_ready && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL accept_timeout: score_ready=%0d required 1", bus.score_ready);
    end
    tick();
    bus.score_valid = 1'b0;
    repeat (gap) tick();
  endtask
  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tests += 6;
    if (bus.score_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0d required 1", bus.score_ready); end
    if (bus.result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0d required 0", bus.result_valid); end
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0d required 0", bus.busy); end
    if (bus.result_class !== 4'd0) begin fails++; $display("FAIL reset_class: got %0d required 0", bus.result_class); end
    if (bus.result_score !== 8'd0) begin fails++; $display("FAIL reset_score: got %0d required 0", bus.result_score); end
    if (bus.result_margin !== 8'd0) begin fails++; $display("FAIL reset_margin: got %0d required 0", bus.result_margin); end
  endtask
  // gapmode 0: back-to-back, 1: every other cycle, 2: random gaps
  task automatic test_set(input string name, input logic [7:0] s[$], input int gapmode, input bit do_ack);
    logic [3:0] c;
    logic [7:0] m, g;
    model(s, c, m, g);
    for (int i = 0; i < s.size(); i++) begin
      send(s[i], i == s.size() - 1 ? 0 : gapmode == 1 ? 1 : gapmode == 2 ? int'($urandom_range(0, 2)) : 0);
      if (i == 0) begin
        tests++;
        if (bus.busy !== 1'b1) begin fails++; $display("FAIL %s_busy_first: got %0d required 1", name, bus.busy); end
      end
    end
    tests += 6;
    if (bus.result_valid !== 1'b1) begin fails++; $display("FAIL %s_valid: got %0d required 1", name, bus.result_valid); end
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL %s_busy: got %0d required 0", name, bus.busy); end
    if (bus.score_ready !== 1'b0) begin fails++; $display("FAIL %s_ready: got %0d required 0", name, bus.score_ready); end
    if (bus.result_class !== c) begin fails++; $display("FAIL %s_class: got %0d required %0d", name, bus.result_class, c); end
    if (bus.result_score !== m) begin fails++; $display("FAIL %s_score: got %0d required %0d", name, bus.result_score, m); end
    if (bus.result_margin !== g) begin fails++; $display("FAIL %s_margin: got %0d required %0d", name, bus.result_margin, g); end
    if (do_ack) begin
      bus.result_ack = 1'b1;
      tick();
      bus.result_ack = 1'b0;
      tests += 3;
      if (bus.result_valid !== 1'b0) begin fails++; $display("FAIL %s_ack_valid: got %0d required 0", name, bus.result_valid); end
      if (bus.score_ready !== 1'b1) begin fails++; $display("FAIL %s_ack_ready: got %0d required 1", name, bus.score_ready); end
      if (bus.result_score !== m) begin fails++; $display("FAIL %s_ack_hold: got %0d required %0d", name, bus.result_score, m); end
    end
  endtask
  task automatic test_directed();
    logic [7:0] q[$];
    q = '{8'd10, 8'd20, 8'd200, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    test_set("b2b", q, 0, 1'b1);
    q = '{8'd5, 8'd100, 8'd7, 8'd100, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    test_set("tie", q, 0, 1'b1);
    q = '{8'd11, 8'd3, 8'd50, 8'd9, 8'd77, 8'd76, 8'd0, 8'd77, 8'd1, 8'd2};
    test_set("gaps", q, 1, 1'b1);
  endtask
  task automatic test_hold();
    logic [7:0] q[$];
    q = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    test_set("zeros", q, 0, 1'b0);
    bus.score_valid = 1'b1;
    bus.score_data = 8'd99;
    repeat (5) begin
      tick();
      tests += 4;
      if (bus.score_ready !== 1'b0) begin fails++; $display("FAIL hold_ready: got %0d required 0", bus.score_ready); end
      if (bus.result_valid !== 1'b1) begin fails++; $display("FAIL hold_valid: got %0d required 1", bus.result_valid); end
      if (bus.result_score !== 8'd0) begin fails++; $display("FAIL hold_score: got %0d required 0", bus.result_score); end
      if (bus.result_class !== 4'd0) begin fails++; $display("FAIL hold_class: got %0d required 0", bus.result_class); end
    end
    bus.score_valid = 1'b0;
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    tests += 2;
    if (bus.score_ready !== 1'b1) begin fails++; $display("FAIL hold_ack_ready: got %0d required 1", bus.score_ready); end
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL hold_ack_busy: got %0d required 0", bus.busy); end
    q = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255};
    test_set("last255", q, 0, 1'b1);
  endtask
  task automatic test_abort();
    logic [7:0] q[$];
    for (int i = 0; i < 6; i++) send(8'(200 + i), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests += 3;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_reset_busy: got %0d required 0", bus.busy); end
    if (bus.score_ready !== 1'b1) begin fails++; $display("FAIL abort_reset_ready: got %0d required 1", bus.score_ready); end
    if (bus.result_valid !== 1'b0) begin fails++; $display("FAIL abort_reset_valid: got %0d required 0", bus.result_valid); end
    q = '{8'd4, 8'd8, 8'd15, 8'd16, 8'd23, 8'd42, 8'd1, 8'd2, 8'd3, 8'd5};
    test_set("after_reset", q, 0, 1'b1);
    for (int i = 0; i < 3; i++) send(8'd250, 0);
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    tests += 5;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL clear_busy: got %0d required 0", bus.busy); end
    if (bus.result_valid !== 1'b0) begin fails++; $display("FAIL clear_valid: got %0d required 0", bus.result_valid); end
    if (bus.result_class !== 4'd5) begin fails++; $display("FAIL clear_class_hold: got %0d required 5", bus.result_class); end
    if (bus.result_score !== 8'd42) begin fails++; $display("FAIL clear_score_hold: got %0d required 42", bus.result_score); end
    if (bus.result_margin !== 8'd19) begin fails++; $display("FAIL clear_margin_hold: got %0d required 19", bus.result_margin); end
    q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd9, 8'd8, 8'd0};
    test_set("after_clear", q, 0, 1'b1);
  endtask
  task automatic test_clear_last();
    logic [7:0] q[$];
    for (int i = 0; i < 9; i++) send(8'd240, 0);
    bus.score_valid = 1'b1;
    bus.score_data = 8'd255;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.score_valid = 1'b0;
    tests += 4;
    if (bus.result_valid !== 1'b0) begin fails++; $display("FAIL clrlast_valid: got %0d required 0", bus.result_valid); end
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL clrlast_busy: got %0d required 0", bus.busy); end
    if (bus.score_ready !== 1'b1) begin fails++; $display("FAIL clrlast_ready: got %0d required 1", bus.score_ready); end
    if (bus.result_score !== 8'd9) begin fails++; $display("FAIL clrlast_score_hold: got %0d required 9", bus.result_score); end
    q = '{8'd3, 8'd30, 8'd12, 8'd29, 8'd30, 8'd1, 8'd0, 8'd2, 8'd6, 8'd7};
    test_set("after_clrlast", q, 2, 1'b1);
  endtask
  task automatic test_random();
    logic [7:0] q[$];
    for (int k = 0; k < 12; k++) begin
      q.delete();
      for (int i = 0; i < 10; i++) q.push_back(k % 3 == 0 ? 8'($urandom_range(0, 4)) : 8'($urandom));
      test_set($sformatf("rand%0d", k), q, 2, 1'b1);
    end
  endtask
  initial begin
    bus.clear = 1'b0;
    bus.score_valid = 1'b0;
    bus.score_data = '0;
    bus.result_ack = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_abort();
    test_clear_last();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
